clk_div_monitor: RTL and testbench

CLK_DIV_MONITOR -- requirements
Module: clk_div_monitor

---
 rtl/clk_div_monitor.sv | 222 ++++++++++++++++++++++
 tb/tb_clk_div_monitor.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_monitor.sv
// ---------------------------------------------------------------------------
// clk_div_monitor
//
// Watches a divided clock (clk_in) that is generated from clk and therefore
// sampled directly as data. Every level change is an edge; the number of clk
// cycles the previous level lasted is the "measured half". The monitor:
//   - reports the last full period (high half + low half) on each rising
//     edge that has a measured high half before it,
//   - runs a SEARCH / ACQUIRE / LOCKED state machine that locks after
//     LOCK_COUNT consecutive halves equal to exp_half,
//   - pulses err and bumps a saturating err_count when lock is lost, either
//     through a mismatching half or through a stuck input (timeout).
//
// Ports
//   clk           in   1  system clock, rising edge
//   reset         in   1  synchronous active-high reset
//   clk_in        in   1  divided clock under test
//   exp_half      in   8  expected half-period in clk cycles (0 never matches)
//   period        out  9  last measured full period, registered
//   period_valid  out  1  one-cycle pulse when period updates
//   locked        out  1  high while the FSM is in LOCKED
//   err           out  1  one-cycle pulse on loss of lock
//   err_count     out  8  saturating count of err pulses
//
// Parameter
//   LOCK_COUNT    consecutive matching halves needed to lock (1..15)
// ---------------------------------------------------------------------------
module clk_div_monitor #(
    parameter int unsigned LOCK_COUNT = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clk_in,
    input  logic [7:0] exp_half,
    output logic [8:0] period,
    output logic       period_valid,
    output logic       locked,
    output logic       err,
    output logic [7:0] err_count
);

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    localparam logic [3:0] LOCK_TGT = 4'(LOCK_COUNT);
    localparam logic [7:0] HALF_MAX = 8'd255;

    // Registers
    state_t     state_q;
    logic       sig_q;          // clk_in delayed by one clk
    logic [7:0] half_cnt_q;     // cycles spent in the current level
    logic [3:0] match_cnt_q;    // consecutive matching halves in ACQUIRE
    logic       seen_edge_q;    // at least one edge since reset
    logic [7:0] high_half_q;    // most recent measured high half
    logic       high_valid_q;
    logic [8:0] period_q;
    logic       period_valid_q;
    logic       locked_q;
    logic       err_q;
    logic [7:0] err_count_q;

    // Next-state values
    state_t     state_d;
    logic [3:0] match_cnt_d;
    logic [7:0] half_cnt_d;
    logic [7:0] err_count_d;
    logic       err_d;

    // Combinational helpers
    logic       edge_s;
    logic       rise_s;
    logic       fall_s;
    logic       meas_valid_s;
    logic       match_s;
    logic       timeout_s;
    logic       period_upd_s;
    logic [3:0] match_inc_s;

    // Edge detection and measurement qualification.
    always_comb begin
        edge_s       = clk_in ^ sig_q;
        rise_s       = edge_s & clk_in;
        fall_s       = edge_s & ~clk_in;
        // The first edge after reset has no earlier reference edge.
        meas_valid_s = edge_s & seen_edge_q;
        // half_cnt_q holds the length of the level that just ended.
        match_s      = (exp_half != 8'd0) && (half_cnt_q == exp_half);
        // Fires only on the 254 -> 255 step, so once per stuck interval;
        // an edge in the same cycle takes precedence.
        timeout_s    = !edge_s && (half_cnt_q == 8'd254);
        period_upd_s = rise_s & meas_valid_s & high_valid_q;
        match_inc_s  = match_cnt_q + 4'd1;
    end

    // Half-period counter: restart on every edge, saturate at 255.
    always_comb begin
        half_cnt_d = half_cnt_q;
        if (edge_s) begin
            half_cnt_d = 8'd1;
        end else if (half_cnt_q != HALF_MAX) begin
            half_cnt_d = half_cnt_q + 8'd1;
        end else begin
            half_cnt_d = half_cnt_q;
        end
    end

    // Lock state machine transitions and loss-of-lock detection.
    always_comb begin
        state_d     = state_q;
        match_cnt_d = match_cnt_q;
        err_d       = 1'b0;
        case (state_q)
            SEARCH: begin
                if (edge_s) begin
                    state_d     = ACQUIRE;
                    match_cnt_d = 4'd0;
                end else begin
                    state_d     = SEARCH;
                end
            end
            ACQUIRE: begin
                if (edge_s) begin
                    if (match_s) begin
                        if (match_inc_s == LOCK_TGT) begin
                            state_d     = LOCKED;
                            match_cnt_d = 4'd0;
                        end else begin
                            match_cnt_d = match_inc_s;
                        end
                    end else begin
                        match_cnt_d = 4'd0;
                    end
                end else if (timeout_s) begin
                    state_d     = SEARCH;
                    match_cnt_d = 4'd0;
                end else begin
                    state_d     = ACQUIRE;
                end
            end
            LOCKED: begin
                if (edge_s) begin
                    if (!match_s) begin
                        state_d     = ACQUIRE;
                        match_cnt_d = 4'd0;
                        err_d       = 1'b1;
                    end else begin
                        state_d     = LOCKED;
                    end
                end else if (timeout_s) begin
                    state_d     = SEARCH;
                    match_cnt_d = 4'd0;
                    err_d       = 1'b1;
                end else begin
                    state_d     = LOCKED;
                end
            end
            default: begin
                state_d     = SEARCH;
                match_cnt_d = 4'd0;
            end
        endcase
    end

    // Saturating error counter.
    always_comb begin
        err_count_d = err_count_q;
        if (err_d && (err_count_q != 8'hFF)) begin
            err_count_d = err_count_q + 8'd1;
        end else begin
            err_count_d = err_count_q;
        end
    end

    // All state and registered outputs, synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= SEARCH;
            sig_q          <= 1'b0;
            half_cnt_q     <= 8'd0;
            match_cnt_q    <= 4'd0;
            seen_edge_q    <= 1'b0;
            high_half_q    <= 8'd0;
            high_valid_q   <= 1'b0;
            period_q       <= 9'd0;
            period_valid_q <= 1'b0;
            locked_q       <= 1'b0;
            err_q          <= 1'b0;
            err_count_q    <= 8'd0;
        end else begin
            state_q        <= state_d;
            sig_q          <= clk_in;
            half_cnt_q     <= half_cnt_d;
            match_cnt_q    <= match_cnt_d;
            locked_q       <= (state_d == LOCKED);
            err_q          <= err_d;
            err_count_q    <= err_count_d;
            period_valid_q <= period_upd_s;
            if (edge_s) begin
                seen_edge_q <= 1'b1;
            end
            // A falling edge closes a high half; remember it for the period.
            if (fall_s && meas_valid_s) begin
                high_half_q  <= half_cnt_q;
                high_valid_q <= 1'b1;
            end
            // A rising edge closes a low half; both halves now known.
            if (period_upd_s) begin
                period_q <= {1'b0, high_half_q} + {1'b0, half_cnt_q};
            end
        end
    end

    assign period       = period_q;
    assign period_valid = period_valid_q;
    assign locked       = locked_q;
    assign err          = err_q;
    assign err_count    = err_count_q;

endmodule

// File: tb/tb_clk_div_monitor.sv
// ---------------------------------------------------------------------------
// tb_clk_div_monitor
//
// Directed bench for clk_div_monitor with LOCK_COUNT = 4. clk_in is toggled
// on the falling edge of clk, so a toggle followed by N falling edges gives a
// measured half of N. Outputs are read on falling edges; the pulse monitors
// sample 1 time unit after each falling edge.
// ---------------------------------------------------------------------------
module tb_clk_div_monitor;

    logic       clk = 1'b0;
    logic       reset;
    logic       clk_in;
    logic [7:0] exp_half;
    logic [8:0] period;
    logic       period_valid;
    logic       locked;
    logic       err;
    logic [7:0] err_count;

    int n_cmp = 0;
    int n_fail = 0;
    int err_pulses = 0;
    int locked_cycles = 0;

    always #5 clk = ~clk;

    clk_div_monitor #(.LOCK_COUNT(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .clk_in       (clk_in),
        .exp_half     (exp_half),
        .period       (period),
        .period_valid (period_valid),
        .locked       (locked),
        .err          (err),
        .err_count    (err_count)
    );

    // Pulse monitors.
    always @(negedge clk) begin
        #1;
        if (err === 1'b1) err_pulses++;
        if (locked === 1'b1) locked_cycles++;
    end

    // Safety net against a hung run.
    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, expected run to finish");
        $fatal(1);
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Toggle clk_in and advance to the falling edge where the edge result shows.
    task automatic toggle_edge();
        clk_in = ~clk_in;
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset  = 1'b1;
        clk_in = 1'b0;
        repeat (2) @(negedge clk);
        reset  = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (period !== 9'd0) begin n_fail++; $display("FAIL reset_period: got %0d expected 0", period); end
        n_cmp++; if (period_valid !== 1'b0) begin n_fail++; $display("FAIL reset_pvalid: got %b expected 0", period_valid); end
        n_cmp++; if (locked !== 1'b0) begin n_fail++; $display("FAIL reset_locked: got %b expected 0", locked); end
        n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", err); end
        n_cmp++; if (err_count !== 8'd0) begin n_fail++; $display("FAIL reset_errcnt: got %0d expected 0", err_count); end
    endtask

    // Even division by 8: lock one cycle after the 5th edge, period 8 on rises.
    task automatic test_lock();
        logic exp_l;
        logic exp_pv;
        wait_cyc(3);
        for (int e = 1; e <= 5; e++) begin
            toggle_edge();
            exp_l  = (e == 5);
            exp_pv = (e >= 3) && clk_in;
            n_cmp++; if (locked !== exp_l) begin n_fail++; $display("FAIL lock_edge%0d: locked=%b expected %b", e, locked, exp_l); end
            n_cmp++; if (period_valid !== exp_pv) begin n_fail++; $display("FAIL lock_pvalid%0d: got %b expected %b", e, period_valid, exp_pv); end
            if (exp_pv) begin
                n_cmp++; if (period !== 9'd8) begin n_fail++; $display("FAIL lock_period%0d: got %0d expected 8", e, period); end
            end
            @(negedge clk);
            n_cmp++; if (period_valid !== 1'b0) begin n_fail++; $display("FAIL lock_pv_drop%0d: got %b expected 0", e, period_valid); end
            wait_cyc(2);
        end
    endtask

    // One 5-cycle half while locked: single err, then relock after 4 halves.
    task automatic test_stretch();
        logic exp_l;
        wait_cyc(1);
        toggle_edge();
        n_cmp++; if (err !== 1'b1) begin n_fail++; $display("FAIL stretch_err: got %b expected 1", err); end
        n_cmp++; if (locked !== 1'b0) begin n_fail++; $display("FAIL stretch_locked: got %b expected 0", locked); end
        n_cmp++; if (err_count !== 8'd1) begin n_fail++; $display("FAIL stretch_errcnt: got %0d expected 1", err_count); end
        @(negedge clk);
        n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL stretch_err_drop: got %b expected 0", err); end
        wait_cyc(2);
        for (int k = 1; k <= 4; k++) begin
            toggle_edge();
            exp_l = (k == 4);
            n_cmp++; if (locked !== exp_l) begin n_fail++; $display("FAIL relock_half%0d: locked=%b expected %b", k, locked, exp_l); end
            if (k == 1) begin
                n_cmp++; if (period_valid !== 1'b1 || period !== 9'd9) begin n_fail++; $display("FAIL stretch_period: got %0d/%b expected 9/1", period, period_valid); end
            end
            wait_cyc(3);
        end
    endtask

    // exp_half change takes effect on the very next comparison.
    task automatic test_exp_change();
        exp_half = 8'd5;
        wait_cyc(1);
        toggle_edge();
        n_cmp++; if (locked !== 1'b1 || err !== 1'b0) begin n_fail++; $display("FAIL expchg_first: locked/err=%b/%b expected 1/0", locked, err); end
        wait_cyc(4);
        toggle_edge();
        n_cmp++; if (locked !== 1'b1 || err !== 1'b0) begin n_fail++; $display("FAIL expchg_second: locked/err=%b/%b expected 1/0", locked, err); end
        exp_half = 8'd4;
        wait_cyc(3);
    endtask

    // Stuck input while locked: one err 255 cycles after the last edge.
    task automatic test_timeout();
        int first_idx;
        int pulses;
        first_idx = -1;
        pulses    = 0;
        toggle_edge();
        n_cmp++; if (locked !== 1'b1) begin n_fail++; $display("FAIL tmo_prelocked: got %b expected 1", locked); end
        for (int i = 2; i <= 400; i++) begin
            @(negedge clk);
            if (err === 1'b1) begin
                pulses++;
                if (first_idx < 0) first_idx = i;
            end
        end
        n_cmp++; if (first_idx !== 255) begin n_fail++; $display("FAIL tmo_time: err at cycle %0d expected 255", first_idx); end
        n_cmp++; if (pulses !== 1) begin n_fail++; $display("FAIL tmo_pulses: got %0d expected 1", pulses); end
        n_cmp++; if (locked !== 1'b0) begin n_fail++; $display("FAIL tmo_locked: got %b expected 0", locked); end
        n_cmp++; if (err_count !== 8'd2) begin n_fail++; $display("FAIL tmo_errcnt: got %0d expected 2", err_count); end
    endtask

    // High 3 / low 5 with exp_half 4: period 8, never locked, no errors.
    task automatic test_asym();
        int lc0;
        do_reset();
        lc0 = locked_cycles;
        wait_cyc(2);
        for (int i = 0; i < 10; i++) begin
            toggle_edge();
            if (i > 0) begin
                n_cmp++; if (period_valid !== 1'b1 || period !== 9'd8) begin n_fail++; $display("FAIL asym_period%0d: got %0d/%b expected 8/1", i, period, period_valid); end
            end
            wait_cyc(2);
            toggle_edge();
            wait_cyc(4);
        end
        wait_cyc(2);
        n_cmp++; if (locked_cycles - lc0 !== 0) begin n_fail++; $display("FAIL asym_locked: %0d locked cycles expected 0", locked_cycles - lc0); end
        n_cmp++; if (err_count !== 8'd0) begin n_fail++; $display("FAIL asym_errcnt: got %0d expected 0", err_count); end
    endtask

    // 300 loss-of-lock events: err_count saturates at 255.
    task automatic test_saturate();
        int ep0;
        do_reset();
        ep0 = err_pulses;
        wait_cyc(3);
        repeat (5) begin
            toggle_edge();
            wait_cyc(3);
        end
        n_cmp++; if (locked !== 1'b1) begin n_fail++; $display("FAIL sat_initial_lock: got %b expected 1", locked); end
        for (int ev = 1; ev <= 300; ev++) begin
            wait_cyc(1);
            toggle_edge();
            if (ev == 254) begin
                n_cmp++; if (err_count !== 8'd254) begin n_fail++; $display("FAIL sat_errcnt254: got %0d expected 254", err_count); end
            end
            wait_cyc(3);
            repeat (4) begin
                toggle_edge();
                wait_cyc(3);
            end
        end
        n_cmp++; if (err_count !== 8'd255) begin n_fail++; $display("FAIL sat_errcnt: got %0d expected 255", err_count); end
        n_cmp++; if (err_pulses - ep0 !== 300) begin n_fail++; $display("FAIL sat_pulses: got %0d expected 300", err_pulses - ep0); end
        n_cmp++; if (locked !== 1'b1) begin n_fail++; $display("FAIL sat_final_lock: got %b expected 1", locked); end
    endtask

    // One-cycle reset while locked: outputs clear, no err, relock needs 5 edges.
    task automatic test_reset_locked();
        int ep0;
        logic exp_l;
        ep0 = err_pulses;
        reset  = 1'b1;
        clk_in = 1'b0;
        @(negedge clk);
        reset  = 1'b0;
        n_cmp++; if (locked !== 1'b0 || err !== 1'b0 || err_count !== 8'd0 || period !== 9'd0 || period_valid !== 1'b0) begin
            n_fail++; $display("FAIL rstlk_outputs: locked=%b err=%b err_count=%0d period=%0d pv=%b expected all 0", locked, err, err_count, period, period_valid);
        end
        wait_cyc(3);
        n_cmp++; if (err_pulses - ep0 !== 0) begin n_fail++; $display("FAIL rstlk_err: got %0d err pulses expected 0", err_pulses - ep0); end
        for (int e = 1; e <= 5; e++) begin
            toggle_edge();
            exp_l = (e == 5);
            n_cmp++; if (locked !== exp_l) begin n_fail++; $display("FAIL rstlk_edge%0d: locked=%b expected %b", e, locked, exp_l); end
            wait_cyc(3);
        end
    endtask

    initial begin
        reset    = 1'b1;
        clk_in   = 1'b0;
        exp_half = 8'd4;
        test_reset();
        test_lock();
        test_stretch();
        test_exp_change();
        test_timeout();
        test_asym();
        test_saturate();
        test_reset_locked();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
